// File: rtl/sprite_pkg.sv
// Shared types for the sprite scanline scheduler.
//   sched_state_e : scan FSM states.
//   desc_t        : one descriptor-table entry {en, x, y} with coordinates of width CORDW.
package sprite_pkg;

  // Width of the descriptor coordinates; the scheduler's CORDW must match it.
  localparam int unsigned CORDW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic             en;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
  } desc_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder.
//   req   : request mask (bit 0 has highest priority)
//   idx   : index of the lowest set bit, 0 when none
//   valid : at least one bit of req is set
module prio_enc #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx   = W'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_sched.sv
// Per-scanline sprite scheduler: on each line pulse, scans the descriptor table for sprites
// whose top edge is the next line and binds each to the lowest free drawing engine.
//   clk, rst            : clock, asynchronous active-high reset
//   line, frame, sy     : line pulse, frame pulse, current line (valid with line)
//   cfg_we/idx/en/x/y   : descriptor table write port
//   eng_start/x/id      : per-engine start pulse, column and bound descriptor index
//   busy                : scan in progress
//   drop_cnt            : sprites dropped this frame, saturating
//   err                 : sticky flag, line pulse arrived while a scan was running
module sprite_sched
  import sprite_pkg::*;
#(
  parameter int unsigned NSPR   = 8,
  parameter int unsigned NENG   = 2,
  parameter int unsigned SPR_H  = 8,
  parameter int unsigned VLINES = 525,
  parameter int unsigned CORDW  = sprite_pkg::CORDW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   line,
  input  logic                                   frame,
  input  logic signed [CORDW-1:0]                sy,
  input  logic                                   cfg_we,
  input  logic        [$clog2(NSPR)-1:0]         cfg_idx,
  input  logic                                   cfg_en,
  input  logic signed [CORDW-1:0]                cfg_x,
  input  logic signed [CORDW-1:0]                cfg_y,
  output logic        [NENG-1:0]                 eng_start,
  output logic        [NENG-1:0][CORDW-1:0]      eng_x,
  output logic        [NENG-1:0][$clog2(NSPR)-1:0] eng_id,
  output logic                                   busy,
  output logic        [7:0]                      drop_cnt,
  output logic                                   err
);

  localparam int unsigned IDW = $clog2(NSPR);
  localparam int unsigned RW  = $clog2(SPR_H + 1);
  localparam int unsigned EW  = (NENG > 1) ? $clog2(NENG) : 1;

  desc_t              tbl_q [NSPR];
  desc_t              cur;

  sched_state_e       state_q, state_d;
  logic [IDW-1:0]     idx_q, idx_d;
  logic [CORDW-1:0]   tgt_q, tgt_next;
  logic [RW-1:0]      rem_q [NENG];
  logic [RW-1:0]      rem_d [NENG];
  logic [NENG-1:0]    free;
  logic [EW-1:0]      free_idx;
  logic               free_valid;
  logic [NENG-1:0]    start_d;
  logic [NENG-1:0][CORDW-1:0] x_d;
  logic [NENG-1:0][IDW-1:0]   id_d;
  logic               drop;
  logic [7:0]         drop_d;

  // Descriptor table; the scan reads the registered copy, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(NSPR); s++) tbl_q[s] <= '0;
    end else if (cfg_we && (32'(cfg_idx) < NSPR)) begin
      tbl_q[cfg_idx] <= '{en: cfg_en, x: cfg_x, y: cfg_y};
    end
  end

  // Line after sy, wrapping at the bottom of the frame.
  assign tgt_next = (sy == CORDW'(VLINES - 1)) ? '0 : sy + CORDW'(1);

  always_comb begin
    for (int e = 0; e < int'(NENG); e++) free[e] = (rem_q[e] == '0);
  end

  prio_enc #(
    .N (NENG),
    .W (EW)
  ) u_prio_enc (
    .req   (free),
    .idx   (free_idx),
    .valid (free_valid)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    start_d = '0;
    x_d     = eng_x;
    id_d    = eng_id;
    drop    = 1'b0;
    cur     = tbl_q[idx_q];

    // Line countdown runs in every state; a bind below overrides it for its engine.
    if (line) begin
      for (int e = 0; e < int'(NENG); e++) begin
        if (rem_q[e] != '0) rem_d[e] = rem_q[e] - RW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (line) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (cur.en && (cur.y == tgt_q)) begin
          if (free_valid) begin
            rem_d[free_idx]   = RW'(SPR_H);
            start_d[free_idx] = 1'b1;
            x_d[free_idx]     = cur.x;
            id_d[free_idx]    = idx_q;
          end else begin
            drop = 1'b1;
          end
        end
        if (idx_q == IDW'(NSPR - 1)) state_d = StDone;
        else                          idx_d   = idx_q + IDW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A frame pulse restarts the count, but a drop in that same cycle still counts.
  always_comb begin
    if (frame)                          drop_d = {7'd0, drop};
    else if (drop && drop_cnt != 8'hFF) drop_d = drop_cnt + 8'd1;
    else                                drop_d = drop_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      tgt_q     <= '0;
      eng_start <= '0;
      eng_x     <= '0;
      eng_id    <= '0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
      err       <= 1'b0;
      for (int e = 0; e < int'(NENG); e++) rem_q[e] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      eng_start <= start_d;
      eng_x     <= x_d;
      eng_id    <= id_d;
      busy      <= (state_d != StIdle);
      drop_cnt  <= drop_d;
      // Target only follows line pulses that actually start a scan.
      if (line && state_q == StIdle) tgt_q <= tgt_next;
      if (line && state_q != StIdle) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_sched.sv
module tb_sprite_sched;

  localparam int NSPR  = 8;
  localparam int NENG  = 2;
  localparam int SPR_H = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              line = 1'b0;
  logic              frame = 1'b0;
  logic signed [15:0] sy = '0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_idx = '0;
  logic              cfg_en = 1'b0;
  logic signed [15:0] cfg_x = '0;
  logic signed [15:0] cfg_y = '0;
  logic [1:0]        eng_start;
  logic [1:0][15:0]  eng_x;
  logic [1:0][2:0]   eng_id;
  logic              busy;
  logic [7:0]        drop_cnt;
  logic              err;

  sprite_sched #(
    .NSPR   (NSPR),
    .NENG   (NENG),
    .SPR_H  (SPR_H),
    .VLINES (525),
    .CORDW  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line      (line),
    .frame     (frame),
    .sy        (sy),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_id    (eng_id),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          eng;
    logic [15:0] x;
    int          id;
    int          at;
  } exp_t;

  typedef struct {
    int idx;
    bit en;
    int x;
    int y;
    int sy;
    bit hit;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   t0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One clock cycle; compares any start pulse against the scoreboard at the falling edge.
  task automatic tick();
    exp_t ex;
    @(negedge clk);
    for (int e = 0; e < NENG; e++) begin
      if (eng_start[e]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got eng=%0d id=%0d cyc=%0d expected no start",
                   e, eng_id[e], cyc);
        end else begin
          ex = exp_q.pop_front();
          if (ex.eng != e || ex.x != eng_x[e] || ex.id != int'(eng_id[e]) || ex.at != cyc) begin
            errors++;
            $display("FAIL start: got eng=%0d x=%0d id=%0d cyc=%0d expected eng=%0d x=%0d id=%0d cyc=%0d",
                     e, eng_x[e], eng_id[e], cyc, ex.eng, ex.x, ex.id, ex.at);
          end
        end
      end
    end
  endtask

  task automatic push(input int eng, input int x, input int id, input int at);
    exp_t ex;
    ex.eng = eng;
    ex.x   = 16'(x);
    ex.id  = id;
    ex.at  = at;
    exp_q.push_back(ex);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wr(input int idx, input bit en, input int x, input int y);
    cfg_we  = 1'b1;
    cfg_idx = 3'(idx);
    cfg_en  = en;
    cfg_x   = 16'(x);
    cfg_y   = 16'(y);
    tick();
    cfg_we  = 1'b0;
  endtask

  // Line high for the current cycle (t0); returns at the falling edge of t0+1.
  task automatic pulse_line(input int v);
    line = 1'b1;
    sy   = 16'(v);
    tick();
    line = 1'b0;
  endtask

  task automatic scan_wait();
    repeat (NSPR + 3) tick();
  endtask

  task automatic q_empty(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //         idx en  x    y    sy   hit
    vecs[0] = '{0, 1, 100,  20,  19, 1};
    vecs[1] = '{2, 1,  37,   0, 524, 1};  // frame wrap
    vecs[2] = '{2, 1,  37,   0,   0, 0};
    vecs[3] = '{7, 1,   5,  30,  29, 1};  // last descriptor
    vecs[4] = '{3, 0,   9,  30,  29, 0};  // disabled
    vecs[5] = '{4, 1, 639,  -1,  -2, 1};  // negative line
    vecs[6] = '{5, 1,  12, 100, 100, 0};  // top edge is current line
    vecs[7] = '{1, 1, 200, 524, 523, 1};

    do_reset();
    chk("reset_start", int'(eng_start), 0);
    chk("reset_eng_x", int'(eng_x), 0);
    chk("reset_eng_id", int'(eng_id), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_drop", int'(drop_cnt), 0);
    chk("reset_err", int'(err), 0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      wr(vecs[v].idx, vecs[v].en, vecs[v].x, vecs[v].y);
      t0 = cyc;
      if (vecs[v].hit) push(0, vecs[v].x, vecs[v].idx, t0 + 2 + vecs[v].idx);
      pulse_line(vecs[v].sy);
      scan_wait();
      q_empty($sformatf("vec%0d_pending", v));
      chk($sformatf("vec%0d_drop", v), int'(drop_cnt), 0);
    end

    // Single sprite: start timing and busy window.
    do_reset();
    wr(0, 1, 100, 20);
    chk("a_busy_idle", int'(busy), 0);
    t0 = cyc;
    push(0, 100, 0, t0 + 2);
    pulse_line(19);
    chk("a_busy_t1", int'(busy), 1);
    for (int k = 2; k <= NSPR + 2; k++) begin
      tick();
      chk($sformatf("a_busy_t%0d", k), int'(busy), (k <= NSPR + 1) ? 1 : 0);
    end
    chk("a_eng_x_held", int'(eng_x[0]), 100);
    chk("a_eng_id_held", int'(eng_id[0]), 0);
    q_empty("a_pending");

    // Three sprites on one line, two engines; frame clear and frame/drop coincidence.
    do_reset();
    wr(1, 1, 11, 50);
    wr(3, 1, 33, 50);
    wr(5, 1, 55, 50);
    t0 = cyc;
    push(0, 11, 1, t0 + 3);
    push(1, 33, 3, t0 + 5);
    pulse_line(49);
    scan_wait();
    q_empty("b_pending");
    chk("b_drop1", int'(drop_cnt), 1);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("b_frame_clear", int'(drop_cnt), 0);
    pulse_line(49);            // engines still busy: all three drop
    repeat (3) tick();         // now in the cycle that evaluates entry 3
    frame = 1'b1;
    tick();
    frame = 1'b0;
    scan_wait();
    chk("b_frame_and_drop", int'(drop_cnt), 2);
    q_empty("b_pending2");

    // Engine freed after SPR_H lines can take a sprite exactly SPR_H lines lower.
    do_reset();
    wr(0, 1, 10, 10);
    wr(2, 1, 12, 10);
    wr(1, 1, 11, 18);
    t0 = cyc;
    push(0, 10, 0, t0 + 2);
    push(1, 12, 2, t0 + 4);
    pulse_line(9);
    scan_wait();
    for (int s = 10; s <= 16; s++) begin
      pulse_line(s);
      scan_wait();
    end
    t0 = cyc;
    push(0, 11, 1, t0 + 3);
    pulse_line(17);
    scan_wait();
    q_empty("c_pending");
    chk("c_no_drop", int'(drop_cnt), 0);

    do_reset();
    wr(0, 1, 10, 10);
    wr(2, 1, 12, 10);
    wr(1, 1, 11, 17);
    t0 = cyc;
    push(0, 10, 0, t0 + 2);
    push(1, 12, 2, t0 + 4);
    pulse_line(9);
    scan_wait();
    for (int s = 10; s <= 16; s++) begin
      pulse_line(s);
      scan_wait();
    end
    q_empty("c2_pending");
    chk("c2_drop", int'(drop_cnt), 1);

    // Line pulse during a scan: sticky err, extra countdown, no rescan.
    do_reset();
    wr(0, 1, 10, 20);
    wr(1, 1, 11, 20);
    wr(2, 1, 22, 27);
    wr(3, 1, 33, 100);
    t0 = cyc;
    push(0, 10, 0, t0 + 2);
    push(1, 11, 1, t0 + 3);
    pulse_line(19);
    scan_wait();
    chk("d_err_before", int'(err), 0);
    t0 = cyc;
    pulse_line(20);
    tick();
    tick();
    pulse_line(99);            // in cycle t0+3
    repeat (6) tick();         // cycle t0+10 = t0+NSPR+2
    chk("d_busy_end", int'(busy), 0);
    tick();
    chk("d_no_rescan", int'(busy), 0);
    chk("d_err", int'(err), 1);
    for (int s = 21; s <= 25; s++) begin
      pulse_line(s);
      scan_wait();
    end
    chk("d_drop_none", int'(drop_cnt), 0);
    t0 = cyc;
    push(0, 22, 2, t0 + 4);
    pulse_line(26);
    scan_wait();
    q_empty("d_pending");
    chk("d_drop_final", int'(drop_cnt), 0);
    chk("d_err_sticky", int'(err), 1);

    // Drop counter saturation: all eight descriptors on the same line.
    do_reset();
    for (int i = 0; i < NSPR; i++) wr(i, 1, 300 + i, 50);
    for (int p = 0; p < 40; p++) begin
      t0 = cyc;
      if (p % SPR_H == 0) begin
        push(0, 300, 0, t0 + 2);
        push(1, 301, 1, t0 + 3);
      end
      pulse_line(49);
      scan_wait();
    end
    q_empty("e_pending");
    chk("e_saturate", int'(drop_cnt), 255);

    // Reset in the middle of a scan.
    do_reset();
    wr(0, 1, 100, 20);
    wr(3, 1, 77, 20);
    t0 = cyc;
    push(0, 100, 0, t0 + 2);
    pulse_line(19);
    tick();                    // cycle t0+2: start for entry 0
    line = 1'b1;
    tick();
    line = 1'b0;
    chk("f_err_set", int'(err), 1);
    chk("f_eng_x_set", int'(eng_x[0]), 100);
    rst = 1'b1;
    #1;
    chk("f_rst_start", int'(eng_start), 0);
    chk("f_rst_eng_x", int'(eng_x), 0);
    chk("f_rst_eng_id", int'(eng_id), 0);
    chk("f_rst_busy", int'(busy), 0);
    chk("f_rst_err", int'(err), 0);
    tick();
    rst = 1'b0;
    q_empty("f_pending");
    pulse_line(19);
    chk("f_rescan_busy", int'(busy), 1);
    scan_wait();
    q_empty("f_no_start");
    chk("f_drop", int'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_sched.md
# sprite_sched

Per-scanline scheduler that shares a small pool of `sprite` drawing engines among a larger table of sprite descriptors. At each line pulse it scans the descriptor table, finds sprites whose top edge is the next scanline, binds each to a free engine, and issues that engine's one-cycle `start` and horizontal position. It sits between the CPU-visible sprite registers and the `sprite` instances. It tracks engine occupancy by counting lines, so the engines need no busy output.

## Interface
- `NSPR`, default 8: number of sprite descriptors; ≥2.
- `NENG`, default 2: number of sprite engines; 1..NSPR.
- `SPR_H`, default 8: drawn sprite height in lines (HEIGHT*SCALE_Y of engines).
- `VLINES`, default 525: total lines per frame including blanking.
- `CORDW`, default 16: coordinate width, signed.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `line` in 1: one-cycle pulse at start of horizontal blanking of line `sy`.
- `frame` in 1: one-cycle pulse at frame start.
- `sy` in CORDW signed: current line, valid when `line`=1.
- `cfg_we` in 1: descriptor write strobe.
- `cfg_idx` in $clog2(NSPR): descriptor index.
- `cfg_en` in 1: sprite enable.
- `cfg_x`, `cfg_y` in CORDW signed: sprite left column, top line.
- `eng_start` out NENG: per-engine one-cycle start pulse.
- `eng_x` out NENG×CORDW: per-engine `sprx`, held until rebound.
- `eng_id` out NENG×$clog2(NSPR): descriptor bound to each engine.
- `busy` out 1: scan in progress.
- `drop_cnt` out 8: sprites dropped this frame, saturating.
- `err` out 1: sticky protocol violation.

## Operation
- Descriptor table: NSPR entries {en, x, y}. `cfg_we` writes entry `cfg_idx` at the clock edge. Writes are accepted in any state.
- Target line: `tgt` = 0 if `sy` == VLINES-1, else `sy`+1. It is latched on `line`.
- Occupancy: per engine, `rem[e]` counts lines remaining, width $clog2(SPR_H+1). Engine is free iff `rem[e]`==0.
  - Every `line` pulse decrements each nonzero `rem`, in any state.
  - The decrement takes effect before the scan that the same pulse triggers.
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on `line`. Scan index `i` starts at 0.
  - SCAN evaluates entry `i` each cycle, `i`++.
  - SCAN→DONE after `i`=NSPR-1.
  - DONE→IDLE unconditionally.
- Qualify: `en`=1 and `y`==`tgt`.
  - Qualifying entry with a free engine: bind to the lowest-indexed free engine. Load `rem[e]`=SPR_H, `eng_x[e]`=x, `eng_id[e]`=i, and pulse `eng_start[e]` the next cycle.
  - An engine bound in this scan is not free for later entries in the same scan.
- Priority: lower descriptor index wins.
- Qualifying entry with no free engine: dropped, `drop_cnt`++ (saturates at 255).
- `frame` clears `drop_cnt`. If `frame` and a drop coincide, the result is 1.
- `line` during SCAN or DONE:
  - The decrement is still applied.
  - No rescan occurs; the current scan finishes with the old `tgt`.
  - `err` is set until reset.
- A write to entry `i` in the same cycle SCAN evaluates entry `i`: the scan sees the old value.
- Sprite column contract: software keeps `x` in 1..active width-1. The scheduler does not check it.
- Reset state: state IDLE; all entries en=0, x=0, y=0; `rem` 0; `eng_start` 0; `eng_x` 0; `eng_id` 0; `busy` 0; `drop_cnt` 0; `err` 0.

## Timing
- `line` at cycle T: SCAN evaluates entry `i` in cycle T+1+i.
- `eng_start` for entry `i` is asserted in cycle T+2+i, exactly one cycle wide. `eng_x`/`eng_id` are valid in that same cycle.
- `busy`=1 for cycles T+1..T+NSPR+1, covering SCAN and DONE.
- Horizontal blanking must exceed NSPR+2 cycles.
- Engine bound at line pulse of `y`-1 draws lines `y`..`y`+SPR_H-1. It is free again after the pulse at line `y`+SPR_H-1, so it can be rebound for a sprite at `y`+SPR_H.
- All outputs are registered.

## Structure
- `sprite_pkg`: FSM state enum; descriptor struct {en, x, y} parameterised by CORDW.
- Sub-module `prio_enc`: combinational lowest-set-bit encoder over the NENG free mask, outputting index and valid. It is instantiated once.

## Test plan
- Reset, write entry 0 {en=1, x=100, y=20}, pulse `line` with `sy`=19 at T → `eng_start[0]`=1 at T+2 only, `eng_x[0]`=100, `eng_id[0]`=0, `busy` high T+1..T+9.
- NENG=2, entries 1, 3, 5 all y=50; `line` `sy`=49 → engine 0←1 at T+3, engine 1←3 at T+5, entry 5 dropped, `drop_cnt`=1; `frame` → `drop_cnt`=0.
- Entry 0 y=10, entry 1 y=18, NENG=1, SPR_H=8 → entry 1 bound at `sy`=17 pulse, with no drop. With entry 1 y=17, it is dropped.
- Entry 2 y=0, `line` with `sy`=524 → start issued (wrap). `sy`=0 → no start.
- `line` pulse at T+3 during a scan → `err`=1, scan completes, `rem` decremented twice, no second scan.
- `rst` asserted mid-SCAN → outputs immediately at reset values, table cleared, the next `line` produces no starts.
